multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 No parameters; all widths are fixed.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 op  in  7  Instr[6:0] from the instruction register.
REQ-005 funct3  in  3  Instr[14:12].
REQ-006 funct7b5  in  1  Instr[30].
REQ-007 Zero  in  1  ALU zero flag, registered by the datapath.
REQ-008 PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite  out  1 each  datapath enables and selects.
REQ-009 ResultSrc, ALUSrcA, ALUSrcB  out  2 each  mux selects.
REQ-010 ImmSrc  out  2  immediate format: 00 I, 01 S, 10 B, 11 J.
REQ-011 ALUControl  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-012 Illegal  out  1  sticky illegal-opcode flag; present only with MCC_ILLEGAL_TRAP_EN.

Function
REQ-013 Moore FSM states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL (+TRAP under macro); one state advance per clk.
REQ-014 Transitions: FETCH->DECODE. DECODE: lw/sw (0000011/0100011)->MEMADR; R (0110011)->EXECUTER; I-ALU (0010011)->EXECUTEI; beq (1100011)->BEQ; jal (1101111)->JAL; other opcodes -> see REQ-026.
REQ-015 MEMADR: lw->MEMREAD, sw->MEMWRITE. MEMREAD->MEMWB. EXECUTER/EXECUTEI/JAL->ALUWB. MEMWB, MEMWRITE, ALUWB, BEQ->FETCH.
REQ-016 Cycle counts including FETCH: lw 5, sw 4, R 4, I 4, jal 4, beq 3.
REQ-017 FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1.
REQ-018 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00. MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
REQ-019 MEMREAD: ResultSrc=00, AdrSrc=1. MEMWB: ResultSrc=01, RegWrite=1. MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1.
REQ-020 EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. ALUWB: ResultSrc=00, RegWrite=1.
REQ-021 BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
REQ-022 Unlisted outputs are 0 in every state.
REQ-023 PCWrite = PCUpdate | (Branch & Zero), combinational.
REQ-024 ImmSrc decoded combinationally from op, independent of state: lw/I-ALU 00, sw 01, beq 10, jal 11, others 00.
REQ-025 ALUControl from ALUOp: 00->000, 01->001; 10->by funct3: 000 gives sub if funct7b5&op[5], else add; 010->101, 110->011, 111->010, other funct3->000.
REQ-026 Illegal opcode in DECODE without macro: return to FETCH; no write enable asserted.

Reset
REQ-027 reset asserted at any time, including mid-instruction: state->FETCH asynchronously.
REQ-028 While reset is high, PCWrite, IRWrite, RegWrite and MemWrite are 0; Illegal is 0.
REQ-029 First FETCH cycle is the first rising clk after reset deasserts.

Configuration
REQ-030 MCC_ILLEGAL_TRAP_EN defined: illegal opcode in DECODE->TRAP; all enables 0; Illegal=1 from TRAP entry; state held until reset.
REQ-031 MCC_ILLEGAL_TRAP_EN undefined: no TRAP state and no Illegal port; REQ-026 applies.

Structure
REQ-032 Shared package mcc_pkg holds the state enum, opcode constants, ALUOp, ImmSrc and ALUControl encodings.
REQ-033 Sub-module alu_dec implements REQ-025; the FSM and ImmSrc decode live in multicycle_ctrl.

Verification
REQ-034 Reset mid-MEMREAD -> state FETCH immediately; RegWrite=0; FETCH outputs on the first clk after release.
REQ-035 op=0000011 (lw) -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 only in cycle 5; ImmSrc=00.
REQ-036 op=1100011 (beq), Zero=1 -> PCWrite=1 in BEQ, ALUControl=001, ImmSrc=10; with Zero=0 -> PCWrite=0.
REQ-037 op=0110011, funct3=000, funct7b5=1 -> ALUControl=001 in EXECUTER; op=0010011 with the same fields -> 000.
REQ-038 op=1101111 (jal) -> ImmSrc=11; PCWrite=1 in JAL; RegWrite=1 in ALUWB; next state FETCH.
REQ-039 op=1111111 -> macro defined: Illegal=1, held until reset; macro undefined: FETCH after DECODE, no writes.

Source files
------------

// File: rtl/mcc_pkg.sv
// Shared definitions for the multicycle RISC-V controller: FSM state
// encoding, opcodes, ALUOp / ImmSrc / ALUControl encodings and the
// per-state control word. The TRAP state exists only when
// MCC_ILLEGAL_TRAP_EN is defined.
package mcc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
`ifdef MCC_ILLEGAL_TRAP_EN
    , S_TRAP   = 4'd11
`endif
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctl_t;

  typedef struct packed {
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    alu_op_t    alu_op;
  } ctrl_t;

  // Moore output table: the control word each state drives
  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    c.alu_op = ALUOP_ADD;
    case (s)
      S_FETCH: begin
        c.ir_write   = 1'b1;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
        c.pc_update  = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        c.adr_src = 1'b1;
      end
      S_MEMWB: begin
        c.result_src = 2'b01;
        c.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        c.adr_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      S_EXECUTER: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        c.reg_write = 1'b1;
      end
      S_BEQ: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = ALUOP_SUB;
        c.branch    = 1'b1;
      end
      S_JAL: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b10;
        c.pc_update = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_dec.sv
// ALU decoder: turns the FSM's ALUOp plus the instruction's funct
// fields into the 3-bit ALU operation select.
module alu_dec
  import mcc_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op_b5,
  output logic [2:0] alu_control
);

  // Fixed add/sub for address and branch work, funct3 decode otherwise
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (funct7b5 & op_b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V controller: Moore FSM with registered control word,
// combinational PCWrite and ImmSrc, and an alu_dec instance.
// Optional feature: define MCC_ILLEGAL_TRAP_EN to park unknown opcodes
// in a TRAP state and raise the sticky Illegal output; without it an
// unknown opcode simply returns to FETCH.
module multicycle_ctrl
  import mcc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl
`ifdef MCC_ILLEGAL_TRAP_EN
  ,
  output logic       Illegal
`endif
);

  state_t state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;
`ifdef MCC_ILLEGAL_TRAP_EN
  logic   illegal_q, illegal_d;
`endif

  // Next-state logic; the control word for the next state is looked up
  // here so the outputs come straight from flops
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
`ifdef MCC_ILLEGAL_TRAP_EN
          default:      state_d = S_TRAP;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECUTER,
      S_EXECUTEI,
      S_JAL:      state_d = S_ALUWB;
      S_MEMWB,
      S_MEMWRITE,
      S_ALUWB,
      S_BEQ:      state_d = S_FETCH;
`ifdef MCC_ILLEGAL_TRAP_EN
      S_TRAP:     state_d = S_TRAP;
`endif
      default:    state_d = S_FETCH;
    endcase
    ctrl_d = state_ctrl(state_d);
`ifdef MCC_ILLEGAL_TRAP_EN
    illegal_d = illegal_q | (state_d == S_TRAP);
`endif
  end

  // State and control-word registers; reset parks the machine in FETCH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      ctrl_q  <= state_ctrl(S_FETCH);
`ifdef MCC_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
`ifdef MCC_ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  // Immediate format depends only on the opcode, not on the state
  always_comb begin
    ImmSrc = IMM_I;
    case (op)
      OP_LW, OP_I: ImmSrc = IMM_I;
      OP_SW:       ImmSrc = IMM_S;
      OP_BEQ:      ImmSrc = IMM_B;
      OP_JAL:      ImmSrc = IMM_J;
      default:     ImmSrc = IMM_I;
    endcase
  end

  alu_dec u_alu_dec (
    .alu_op      (ctrl_q.alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op_b5       (op[5]),
    .alu_control (ALUControl)
  );

  // Write enables are forced low while reset is held, even though the
  // registered word already shows FETCH
  assign PCWrite   = ~reset & (ctrl_q.pc_update | (ctrl_q.branch & Zero));
  assign IRWrite   = ~reset & ctrl_q.ir_write;
  assign RegWrite  = ~reset & ctrl_q.reg_write;
  assign MemWrite  = ~reset & ctrl_q.mem_write;
  assign AdrSrc    = ctrl_q.adr_src;
  assign ResultSrc = ctrl_q.result_src;
  assign ALUSrcA   = ctrl_q.alu_src_a;
  assign ALUSrcB   = ctrl_q.alu_src_b;
`ifdef MCC_ILLEGAL_TRAP_EN
  assign Illegal   = illegal_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed instructions, a
// reset in the middle of a load, and randomized instruction streams,
// all compared against a table-driven reference model.
// Honors MCC_ILLEGAL_TRAP_EN the same way the design does.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
`ifdef MCC_ILLEGAL_TRAP_EN
  logic       Illegal;
`endif

  int vecCount  = 0;
  int missCount = 0;

  // Step names used by the reference model to describe each cycle
  localparam int SF    = 0;
  localparam int SD    = 1;
  localparam int SMA   = 2;
  localparam int SMR   = 3;
  localparam int SMWB  = 4;
  localparam int SMW   = 5;
  localparam int SER   = 6;
  localparam int SEI   = 7;
  localparam int SAWB  = 8;
  localparam int SBEQ  = 9;
  localparam int SJAL  = 10;
  localparam int STRAP = 11;

  multicycle_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .Zero       (Zero),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl)
`ifdef MCC_ILLEGAL_TRAP_EN
    ,
    .Illegal    (Illegal)
`endif
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Safety net so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Count every comparison and report any difference
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Sequence of steps an instruction walks through, indexed by cycle
  function automatic int stepOf(input logic [6:0] o, input int idx);
    int seq[6];
    for (int i = 0; i < 6; i++) seq[i] = -1;
    seq[0] = SF;
    seq[1] = SD;
    case (o)
      7'b0000011: begin seq[2] = SMA; seq[3] = SMR; seq[4] = SMWB; end
      7'b0100011: begin seq[2] = SMA; seq[3] = SMW; end
      7'b0110011: begin seq[2] = SER; seq[3] = SAWB; end
      7'b0010011: begin seq[2] = SEI; seq[3] = SAWB; end
      7'b1100011: seq[2] = SBEQ;
      7'b1101111: begin seq[2] = SJAL; seq[3] = SAWB; end
      default: begin
`ifdef MCC_ILLEGAL_TRAP_EN
        for (int i = 2; i < 6; i++) seq[i] = STRAP;
`endif
      end
    endcase
    return (idx < 6) ? seq[idx] : -1;
  endfunction

  // ALU operation the ALU should perform for a given ALUOp request
  function automatic logic [2:0] refAluCtl(input int aluOp, input logic [6:0] o,
                                           input logic [2:0] f3, input logic f7);
    if (aluOp == 0) return 3'b000;
    if (aluOp == 1) return 3'b001;
    case (f3)
      3'b000:  return (f7 && o[5]) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Expected output vector for one step:
  // {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl}
  function automatic logic [13:0] refCtl(input int step, input logic [6:0] o,
                                         input logic [2:0] f3, input logic f7,
                                         input logic z);
    logic pcu, br, adr, mw, irw, rw;
    logic [1:0] res, sa, sb;
    int aop;
    pcu = 0; br = 0; adr = 0; mw = 0; irw = 0; rw = 0;
    res = 2'b00; sa = 2'b00; sb = 2'b00; aop = 0;
    case (step)
      SF:   begin irw = 1; sb = 2'b10; res = 2'b10; pcu = 1; end
      SD:   begin sa = 2'b01; sb = 2'b01; end
      SMA:  begin sa = 2'b10; sb = 2'b01; end
      SMR:  adr = 1;
      SMWB: begin res = 2'b01; rw = 1; end
      SMW:  begin adr = 1; mw = 1; end
      SER:  begin sa = 2'b10; aop = 2; end
      SEI:  begin sa = 2'b10; sb = 2'b01; aop = 2; end
      SAWB: rw = 1;
      SBEQ: begin sa = 2'b10; aop = 1; br = 1; end
      SJAL: begin sa = 2'b01; sb = 2'b10; pcu = 1; end
      default: ;
    endcase
    return {pcu | (br & z), adr, mw, irw, rw, res, sa, sb, refAluCtl(aop, o, f3, f7)};
  endfunction

  // Immediate format expected for an opcode
  function automatic logic [1:0] refImm(input logic [6:0] o);
    case (o)
      7'b0000011, 7'b0010011: return 2'b00;
      7'b0100011:             return 2'b01;
      7'b1100011:             return 2'b10;
      7'b1101111:             return 2'b11;
      default:                return 2'b00;
    endcase
  endfunction

  function automatic logic [13:0] observedCtl();
    return {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
            ALUSrcA, ALUSrcB, ALUControl};
  endfunction

  // Run one instruction from FETCH for up to maxSteps cycles; entered
  // and left 1 ns after a rising edge. zeroMode 0/1 fixes Zero, 2 randomizes it
  task automatic applyStimulus(input logic [6:0] o, input logic [2:0] f3,
                               input logic f7, input int zeroMode,
                               input int maxSteps);
    int s;
    op = o;
    funct3 = f3;
    funct7b5 = f7;
    for (int idx = 0; idx < maxSteps; idx++) begin
      s = stepOf(o, idx);
      if (s < 0) break;
      Zero = (zeroMode == 2) ? 1'($urandom_range(0, 1)) : zeroMode[0];
      #1;
      checkOutput($sformatf("op%07b f3%03b s%0d ctl", o, f3, idx),
                  32'(observedCtl()), 32'(refCtl(s, o, f3, f7, Zero)));
      checkOutput($sformatf("op%07b s%0d imm", o, idx), 32'(ImmSrc), 32'(refImm(o)));
`ifdef MCC_ILLEGAL_TRAP_EN
      checkOutput($sformatf("op%07b s%0d illegal", o, idx), 32'(Illegal),
                  32'(s == STRAP));
`endif
      @(posedge clk);
      #1;
    end
  endtask

  // Pulse reset for one cycle and check the enables stay quiet
  task automatic pulseReset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    #2;
    checkOutput("rst_en", 32'({PCWrite, IRWrite, RegWrite, MemWrite}), 32'd0);
`ifdef MCC_ILLEGAL_TRAP_EN
    checkOutput("rst_illegal", 32'(Illegal), 32'd0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Main sequence: reset, directed cases, mid-load reset, random stream
  initial begin
    logic [13:0] expv;
    logic [6:0]  ro;
    int          cls;
    reset = 1'b0; op = '0; funct3 = '0; funct7b5 = 1'b0; Zero = 1'b0;
    #3 reset = 1'b1;
    #4;
    checkOutput("rst_en", 32'({PCWrite, IRWrite, RegWrite, MemWrite}), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    applyStimulus(7'b0000011, 3'b010, 1'b0, 2, 6);
    applyStimulus(7'b1100011, 3'b000, 1'b0, 1, 6);
    applyStimulus(7'b1100011, 3'b000, 1'b0, 0, 6);
    applyStimulus(7'b0110011, 3'b000, 1'b1, 2, 6);
    applyStimulus(7'b0010011, 3'b000, 1'b1, 2, 6);
    applyStimulus(7'b1101111, 3'b000, 1'b0, 2, 6);
    applyStimulus(7'b0100011, 3'b010, 1'b0, 2, 6);
    applyStimulus(7'b1111111, 3'b000, 1'b0, 2, 6);
`ifdef MCC_ILLEGAL_TRAP_EN
    pulseReset();
`endif

    // Reset arriving mid-MEMREAD must snap straight back to FETCH
    applyStimulus(7'b0000011, 3'b010, 1'b0, 0, 3);
    Zero = 1'b0;
    #1;
    checkOutput("memread_ctl", 32'(observedCtl()),
                32'(refCtl(SMR, 7'b0000011, 3'b010, 1'b0, 1'b0)));
    #2;
    reset = 1'b1;
    #1;
    expv = refCtl(SF, 7'b0000011, 3'b010, 1'b0, 1'b0);
    expv[13] = 1'b0;
    expv[10] = 1'b0;
    checkOutput("rst_midmr_ctl", 32'(observedCtl()), 32'(expv));
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(7'b0000011, 3'b010, 1'b0, 2, 6);

    // Random instruction stream including the odd illegal opcode
    for (int n = 0; n < 150; n++) begin
      cls = $urandom_range(0, 6);
      case (cls)
        0: ro = 7'b0000011;
        1: ro = 7'b0100011;
        2: ro = 7'b0110011;
        3: ro = 7'b0010011;
        4: ro = 7'b1100011;
        5: ro = 7'b1101111;
        default: begin
          ro = 7'($urandom_range(0, 127));
          while (ro == 7'b0000011 || ro == 7'b0100011 || ro == 7'b0110011 ||
                 ro == 7'b0010011 || ro == 7'b1100011 || ro == 7'b1101111)
            ro = 7'($urandom_range(0, 127));
        end
      endcase
      applyStimulus(ro, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 2, 6);
`ifdef MCC_ILLEGAL_TRAP_EN
      if (cls == 6) pulseReset();
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
